// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath/memory.
// The master side is the sequencer: it consumes IR fields and flags, drives selects and strobes.
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [6:0]       opcode;
  logic [2:0]       func3;
  logic             inst30;
  logic             BrEq;
  logic             BrLT;
  logic             mem_ready;
  logic             MemReq;
  logic             MemRW;
  logic             IorD;
  logic             IRWrite;
  logic             MDRWrite;
  logic             PCWrite;
  logic             PCSel;
  logic [2:0]       ImmSel;
  logic             BrUn;
  logic             ASel;
  logic             BSel;
  logic [3:0]       ALUSel;
  logic             RegWEn;
  logic [1:0]       WBSel;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, func3, inst30, BrEq, BrLT, mem_ready,
    output MemReq, MemRW, IorD, IRWrite, MDRWrite, PCWrite, PCSel, ImmSel,
           BrUn, ASel, BSel, ALUSel, RegWEn, WBSel, illegal, state, instret
  );

  modport slave (
    output opcode, func3, inst30, BrEq, BrLT, mem_ready,
    input  MemReq, MemRW, IorD, IRWrite, MDRWrite, PCWrite, PCSel, ImmSel,
           BrUn, ASel, BSel, ALUSel, RegWEn, WBSel, illegal, state, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset sequencer over a shared instruction/data memory port.
// state  | meaning
// FETCH  | request IR from memory at PC, wait for mem_ready
// DECODE | immediate select from opcode, screen unsupported encodings
// EXEC   | ALU operation; branches and jumps retire here
// MEM    | load/store access at ALU result; stores retire here
// WB     | register write-back, PC+4, retire
// TRAP   | sticky illegal-instruction halt, left only through rst
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b101
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_t           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] instret_q;

  logic       is_r, is_addi, is_lw, is_sw, is_br, is_jal, is_jalr, is_auipc, is_lui;
  logic       br_f3_ok, supported, taken;
  logic [2:0] imm_sel;
  logic       a_sel, b_sel;
  logic [3:0] alu_sel;

  always_comb begin
    is_r     = (bus.opcode == OP_R);
    is_addi  = (bus.opcode == OP_ADDI);
    is_lw    = (bus.opcode == OP_LW);
    is_sw    = (bus.opcode == OP_SW);
    is_br    = (bus.opcode == OP_BR);
    is_jal   = (bus.opcode == OP_JAL);
    is_jalr  = (bus.opcode == OP_JALR);
    is_auipc = (bus.opcode == OP_AUIPC);
    is_lui   = (bus.opcode == OP_LUI);
    br_f3_ok = bus.func3 inside {3'b000, 3'b001, 3'b100, 3'b110};
    supported = is_r | is_addi | is_lw | is_sw | (is_br & br_f3_ok) |
                is_jal | is_jalr | is_auipc | is_lui;

    imm_sel = 3'b000;
    case (bus.opcode)
      OP_SW:           imm_sel = 3'b001;
      OP_BR:           imm_sel = 3'b010;
      OP_JAL:          imm_sel = 3'b011;
      OP_AUIPC, OP_LUI: imm_sel = 3'b100;
      OP_R:            imm_sel = 3'b101;
      default:         imm_sel = 3'b000;
    endcase

    case (bus.func3)
      3'b000:  taken = bus.BrEq;
      3'b001:  taken = ~bus.BrEq;
      default: taken = bus.BrLT;
    endcase

    // ALU operand/op selection is a pure function of the opcode, so it is held from EXEC through WB
    a_sel   = is_br | is_jal | is_auipc;
    b_sel   = ~is_r;
    alu_sel = is_lui ? 4'b1111 : ((is_r & bus.inst30) ? 4'b0001 : 4'b0000);
  end

  always_comb begin
    state_d      = state_q;
    bus.MemReq   = 1'b0;
    bus.MemRW    = 1'b1;
    bus.IorD     = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.MDRWrite = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.PCSel    = 1'b0;
    bus.ImmSel   = 3'b000;
    bus.BrUn     = 1'b0;
    bus.ASel     = 1'b0;
    bus.BSel     = 1'b0;
    bus.ALUSel   = 4'b0000;
    bus.RegWEn   = 1'b0;
    bus.WBSel    = 2'b01;

    if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
      bus.ImmSel = imm_sel;
      bus.ASel   = a_sel;
      bus.BSel   = b_sel;
      bus.ALUSel = alu_sel;
    end

    case (state_q)
      S_FETCH: begin
        bus.MemReq = 1'b1;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.ImmSel = imm_sel;
        state_d    = supported ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (is_r | is_addi | is_auipc | is_lui) begin
          state_d = S_WB;
        end else if (is_lw | is_sw) begin
          state_d = S_MEM;
        end else if (is_br) begin
          bus.PCWrite = 1'b1;
          bus.PCSel   = taken;
          bus.BrUn    = (bus.func3 == 3'b110);
          state_d     = S_FETCH;
        end else if (is_jal | is_jalr) begin
          bus.PCSel   = 1'b1;
          bus.PCWrite = 1'b1;
          bus.RegWEn  = 1'b1;
          bus.WBSel   = 2'b10;
          state_d     = S_FETCH;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEM: begin
        bus.MemReq = 1'b1;
        bus.IorD   = 1'b1;
        bus.MemRW  = ~is_sw;
        if (bus.mem_ready) begin
          if (is_sw) begin
            bus.PCWrite = 1'b1;
            state_d     = S_FETCH;
          end else begin
            bus.MDRWrite = 1'b1;
            state_d      = S_WB;
          end
        end
      end
      S_WB: begin
        bus.RegWEn  = 1'b1;
        bus.WBSel   = is_lw ? 2'b00 : 2'b01;
        bus.PCWrite = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = state_q;
    endcase

    // Async reset parks the FSM in FETCH; mask FETCH's request so nothing strobes while rst is high
    if (rst) begin
      bus.MemReq   = 1'b0;
      bus.MemRW    = 1'b1;
      bus.IorD     = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.MDRWrite = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.PCSel    = 1'b0;
      bus.ImmSel   = 3'b000;
      bus.BrUn     = 1'b0;
      bus.ASel     = 1'b0;
      bus.BSel     = 1'b0;
      bus.ALUSel   = 4'b0000;
      bus.RegWEn   = 1'b0;
      bus.WBSel    = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
      if (bus.PCWrite) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign bus.state   = state_q;
  assign bus.illegal = illegal_q;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed and random instructions checked cycle by cycle
// against an instruction-class phase model.
module tb_multicycle_ctrl;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus();
  multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int ninstret = 0;

  typedef enum int {C_R, C_ADDI, C_LW, C_SW, C_BR, C_JAL, C_JALR, C_AUIPC, C_LUI} cls_t;
  typedef enum int {P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_TRAP = 5} ph_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] op_of(cls_t c);
    case (c)
      C_R:     return 7'b0110011;
      C_ADDI:  return 7'b0010011;
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_BR:    return 7'b1100011;
      C_JAL:   return 7'b1101111;
      C_JALR:  return 7'b1100111;
      C_AUIPC: return 7'b0010111;
      default: return 7'b0110111;
    endcase
  endfunction

  function automatic logic [22:0] obs_vec();
    return {bus.state, bus.MemReq, bus.MemRW, bus.IorD, bus.IRWrite, bus.MDRWrite,
            bus.PCWrite, bus.PCSel, bus.ImmSel, bus.BrUn, bus.ASel, bus.BSel,
            bus.ALUSel, bus.RegWEn, bus.WBSel};
  endfunction

  // Expected control word for one cycle of an instruction class in a given phase
  function automatic logic [22:0] ref_vec(ph_t p, cls_t c, logic [2:0] f3, logic i30,
                                          logic eq, logic lt, logic rdy, logic in_rst);
    logic [2:0] st, imm, imm_c;
    logic mreq, mrw, iord, irw, mdrw, pcw, pcs, brun, as, bs, rwe, as_c, bs_c, tk;
    logic [3:0] alu, alu_c;
    logic [1:0] wb;
    st = 3'(int'(p));
    mreq = 0; mrw = 1; iord = 0; irw = 0; mdrw = 0; pcw = 0; pcs = 0;
    imm = 3'b000; brun = 0; as = 0; bs = 0; alu = 4'h0; rwe = 0; wb = 2'b01;
    case (c)
      C_R:            imm_c = 3'b101;
      C_SW:           imm_c = 3'b001;
      C_BR:           imm_c = 3'b010;
      C_JAL:          imm_c = 3'b011;
      C_AUIPC, C_LUI: imm_c = 3'b100;
      default:        imm_c = 3'b000;
    endcase
    as_c  = (c == C_BR) || (c == C_JAL) || (c == C_AUIPC);
    bs_c  = (c != C_R);
    alu_c = (c == C_LUI) ? 4'hF : ((c == C_R && i30) ? 4'h1 : 4'h0);
    tk    = (f3 == 3'd0) ? eq : ((f3 == 3'd1) ? !eq : lt);
    if (p == P_EXEC || p == P_MEM || p == P_WB) begin
      imm = imm_c; as = as_c; bs = bs_c; alu = alu_c;
    end
    case (p)
      P_FETCH:  begin mreq = 1; irw = rdy; end
      P_DECODE: imm = imm_c;
      P_EXEC: begin
        if (c == C_BR) begin pcw = 1; pcs = tk; brun = (f3 == 3'd6); end
        if (c == C_JAL || c == C_JALR) begin pcs = 1; pcw = 1; rwe = 1; wb = 2'b10; end
      end
      P_MEM: begin
        mreq = 1; iord = 1; mrw = (c == C_LW);
        if (rdy) begin
          if (c == C_LW) mdrw = 1; else pcw = 1;
        end
      end
      P_WB: begin rwe = 1; wb = (c == C_LW) ? 2'b00 : 2'b01; pcw = 1; end
      default: ;
    endcase
    if (in_rst) begin
      st = 3'b000; mreq = 0; mrw = 1; iord = 0; irw = 0; mdrw = 0; pcw = 0; pcs = 0;
      imm = 3'b000; brun = 0; as = 0; bs = 0; alu = 4'h0; rwe = 0; wb = 2'b00;
    end
    return {st, mreq, mrw, iord, irw, mdrw, pcw, pcs, imm, brun, as, bs, alu, rwe, wb};
  endfunction

  task automatic run_instr(input cls_t c, input logic [2:0] f3, input logic i30,
                           input logic eq, input logic lt, input int fw, input int mw,
                           input bit abort_mem);
    ph_t  ph[$];
    logic rq[$];
    int   pcw_cnt = 0;
    for (int i = 0; i < fw; i++) begin ph.push_back(P_FETCH); rq.push_back(1'b0); end
    ph.push_back(P_FETCH);  rq.push_back(1'b1);
    ph.push_back(P_DECODE); rq.push_back(1'($urandom));
    ph.push_back(P_EXEC);   rq.push_back(1'($urandom));
    if (c == C_LW || c == C_SW) begin
      for (int i = 0; i < mw; i++) begin ph.push_back(P_MEM); rq.push_back(1'b0); end
      if (!abort_mem) begin ph.push_back(P_MEM); rq.push_back(1'b1); end
    end
    if (c == C_R || c == C_ADDI || c == C_AUIPC || c == C_LUI || c == C_LW) begin
      ph.push_back(P_WB); rq.push_back(1'($urandom));
    end
    for (int k = 0; k < ph.size(); k++) begin
      @(negedge clk);
      if (ph[k] == P_FETCH) begin
        bus.opcode = 7'($urandom); bus.func3 = 3'($urandom); bus.inst30 = 1'($urandom);
      end else begin
        bus.opcode = op_of(c); bus.func3 = f3; bus.inst30 = i30;
      end
      bus.BrEq = eq; bus.BrLT = lt; bus.mem_ready = rq[k];
      #1;
      chk("ctl", 64'(obs_vec()), 64'(ref_vec(ph[k], c, f3, i30, eq, lt, rq[k], 1'b0)));
      chk("ill_instret", 64'({bus.illegal, bus.instret}), 64'({1'b0, CNT_W'(ninstret)}));
      pcw_cnt += int'(bus.PCWrite);
      if (abort_mem && ph[k] == P_MEM) begin
        #1 rst = 1'b1;
        #1;
        chk("abort_ctl", 64'(obs_vec()), 64'(ref_vec(P_FETCH, c, f3, i30, eq, lt, 1'b0, 1'b1)));
        chk("abort_ill_instret", 64'({bus.illegal, bus.instret}), 64'(0));
        chk("abort_pcw", 64'(pcw_cnt), 64'(0));
        ninstret = 0;
        @(negedge clk);
        rst = 1'b0; bus.mem_ready = 1'b0;
        return;
      end
    end
    ninstret++;
    chk("pcwrite_once", 64'(pcw_cnt), 64'(1));
  endtask

  task automatic run_trap(input logic [6:0] op, input logic [2:0] f3);
    @(negedge clk);
    bus.opcode = op; bus.func3 = f3; bus.mem_ready = 1'b1;
    #1 chk("trap_fetch", 64'({bus.state, bus.IRWrite}), 64'({3'b000, 1'b1}));
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1 chk("trap_decode", 64'(bus.state), 64'(1));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.mem_ready = 1'($urandom);
      #1;
      chk("trap_ctl", 64'(obs_vec()), 64'(ref_vec(P_TRAP, C_R, f3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
      chk("trap_ill", 64'({bus.illegal, bus.instret}), 64'({1'b1, CNT_W'(ninstret)}));
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("trap_rst_ctl", 64'(obs_vec()), 64'(ref_vec(P_FETCH, C_R, 3'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));
    chk("trap_rst_ill", 64'({bus.illegal, bus.instret}), 64'(0));
    ninstret = 0;
    @(negedge clk);
    rst = 1'b0; bus.mem_ready = 1'b0;
  endtask

  initial begin
    logic [2:0] brf[4];
    cls_t c;
    logic [2:0] f3;
    brf = '{3'd0, 3'd1, 3'd4, 3'd6};
    bus.opcode = '0; bus.func3 = '0; bus.inst30 = 1'b0;
    bus.BrEq = 1'b0; bus.BrLT = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", 64'(obs_vec()), 64'(ref_vec(P_FETCH, C_R, 3'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1)));
    chk("reset_ill_instret", 64'({bus.illegal, bus.instret}), 64'(0));
    @(negedge clk);
    rst = 1'b0; bus.mem_ready = 1'b0;

    run_instr(C_ADDI,  3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(C_LW,    3'd2, 1'b0, 1'b0, 1'b0, 3, 2, 1'b0);
    run_instr(C_BR,    3'd0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    run_instr(C_BR,    3'd1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    run_instr(C_BR,    3'd6, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    run_instr(C_BR,    3'd4, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    run_instr(C_JAL,   3'd0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
    run_instr(C_JALR,  3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(C_R,     3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(C_R,     3'd0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(C_AUIPC, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(C_LUI,   3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_instr(C_SW,    3'd2, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0);

    for (int n = 0; n < 80; n++) begin
      c  = cls_t'($urandom_range(0, 8));
      f3 = (c == C_BR) ? brf[$urandom_range(0, 3)] : 3'($urandom);
      run_instr(c, f3, 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    run_trap(7'b1110011, 3'd0);
    run_instr(C_ADDI, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    run_trap(7'b1100011, 3'd2);
    run_instr(C_SW, 3'd2, 1'b0, 1'b0, 1'b0, 1, 2, 1'b1);
    run_instr(C_ADDI, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

    @(negedge clk);
    #1 chk("final_instret", 64'({bus.illegal, bus.instret, bus.state}), 64'({1'b0, CNT_W'(ninstret), 3'b000}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I-subset datapath, driving the same datapath select signals and encodings as the single-cycle decoder.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared instruction/data memory port with a ready handshake.
- Raises a sticky trap on unsupported opcodes and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter instret.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  IR[6:0], valid from DECODE onward.
- func3  in  3  IR[14:12].
- inst30  in  1  IR[30]; selects sub versus add.
- BrEq  in  1  comparator equal.
- BrLT  in  1  comparator less-than; honours BrUn.
- mem_ready  in  1  memory completes the current request this cycle.
- MemReq  out  1  memory request valid.
- MemRW  out  1  1=read, 0=write.
- IorD  out  1  memory address: 0=PC, 1=ALU result.
- IRWrite  out  1  load IR from read data.
- MDRWrite  out  1  load MDR from read data.
- PCWrite  out  1  update PC.
- PCSel  out  1  0=PC+4, 1=ALU.
- ImmSel  out  3  I=000, S=001, B=010, J=011, U=100, R=101.
- BrUn  out  1  1=unsigned compare.
- ASel  out  1  0=reg, 1=PC.
- BSel  out  1  0=reg, 1=imm.
- ALUSel  out  4  0000 add, 0001 sub, 1111 pass B.
- RegWEn  out  1  register-file write.
- WBSel  out  2  00 Mem, 01 ALU, 10 PC+4.
- illegal  out  1  sticky trap flag.
- state  out  3  current state, for debug.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- States: FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, TRAP=101.
- Reset (async): state=FETCH, illegal=0, instret=0.
  - While rst=1, all strobes are 0: MemReq, IRWrite, MDRWrite, PCWrite, RegWEn.
  - Selects while rst=1: MemRW=1, all others 0.
- Outputs are combinational from state, opcode, func3 and Br*.
  - Defaults in every state: strobes 0, MemRW=1, PCSel=0, ASel=0, BSel=0, ALUSel=0000, WBSel=01, ImmSel=000, BrUn=0.
- FETCH: MemReq=1, IorD=0.
  - If mem_ready: IRWrite=1, go to DECODE.
  - Else hold FETCH with the request stable.
- DECODE: one cycle; ImmSel set from opcode.
  - Supported opcodes: 0110011 R (add/sub), 0010011 addi, 0000011 lw, 0100011 sw, 1100011 beq/bne/blt/bltu (func3 000/001/100/110), 1101111 jal, 1100111 jalr, 0010111 auipc, 0110111 lui.
  - Any other opcode, or any other branch func3, goes to TRAP; otherwise go to EXEC.
- EXEC:
  - R: BSel=0; ALUSel = inst30 ? 0001 : 0000; go to WB.
  - addi: BSel=1, ALUSel=0000; go to WB.
  - lw/sw: BSel=1, ALUSel=0000, ImmSel I or S; go to MEM.
  - auipc: ASel=1, BSel=1, ALUSel=0000; go to WB.
  - lui: BSel=1, ALUSel=1111; go to WB.
  - Branch: ASel=1, BSel=1, ImmSel=010, ALUSel=0000, BrUn=(func3==110); PCWrite=1.
    - taken = beq:BrEq, bne:!BrEq, blt/bltu:BrLT.
    - PCSel=taken. Retire; go to FETCH.
  - jal: ASel=1, BSel=1, ImmSel=011; jalr: ASel=0, BSel=1, ImmSel=000.
    - Both: PCSel=1, PCWrite=1, RegWEn=1, WBSel=10. Retire; go to FETCH.
- MEM: MemReq=1, IorD=1, MemRW=1 for lw, 0 for sw; ALU inputs held as in EXEC.
  - Wait for mem_ready.
  - lw: MDRWrite=1, go to WB.
  - sw: PCWrite=1, PCSel=0. Retire; go to FETCH.
- WB: RegWEn=1; WBSel=00 for lw, else 01; ALU controls held as in EXEC; PCWrite=1, PCSel=0. Retire; go to FETCH.
- TRAP: illegal=1 (sticky); all strobes 0. Exit only via rst.
- Retire: instret += 1 on the same clock edge as the final PCWrite. Wraps modulo 2^CNT_W.
- mem_ready outside FETCH/MEM is ignored.
- Exactly one PCWrite per instruction.
- rst asserted mid-instruction: immediate return to FETCH, no partial register/PC write after the edge.

Test Plan:
- addi x1,x0,5 with mem_ready=1 every cycle -> states FETCH,DECODE,EXEC,WB; RegWEn=1 and WBSel=01 in WB; instret 0->1 after 4 cycles.
- lw with mem_ready low 3 cycles in FETCH and 2 in MEM -> MemReq held high and IorD stable throughout; MDRWrite one cycle; 5+5=10 cycles total; WBSel=00.
- beq with BrEq=1, then bne with BrEq=1 -> first PCSel=1, second PCSel=0; each PCWrite=1 in EXEC; each retires in 3 cycles.
- bltu with BrLT=1 -> BrUn=1, PCSel=1; blt -> BrUn=0.
- jal -> EXEC: PCSel=1, RegWEn=1, WBSel=10, ImmSel=011.
- opcode 1110011 -> TRAP, illegal=1, no PCWrite/RegWEn for 20 cycles; assert rst -> state=FETCH, illegal=0, instret=0; rst mid-MEM of sw -> MemReq drops, no PCWrite.
